// File: rtl/sram_pkg.sv
// Shared types and defaults for the parametrised single-port SRAM with byte masks and
// a post-reset clear sequencer.
package sram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR,
    ST_IDLE
  } sram_state_e;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAddrWidth = 7;

  function automatic int unsigned wmask_width(int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/sram_1rw_wmask_init_if.sv
// Bus-side access signals of sram_1rw_wmask_init; the controller drives the master modport,
// the SRAM implements the slave modport.
interface sram_1rw_wmask_init_if
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
);

  localparam int unsigned WMASK_WIDTH = wmask_width(DATA_WIDTH);

  logic                   csb0;
  logic                   web0;
  logic [WMASK_WIDTH-1:0] wmask0;
  logic [ADDR_WIDTH-1:0]  addr0;
  logic [DATA_WIDTH-1:0]  din0;
  logic [DATA_WIDTH-1:0]  dout0;
  logic                   rvalid0;
  logic                   busy0;

  modport master (
    output csb0, web0, wmask0, addr0, din0,
    input  dout0, rvalid0, busy0
  );

  modport slave (
    input  csb0, web0, wmask0, addr0, din0,
    output dout0, rvalid0, busy0
  );

endinterface

// File: rtl/sram_clear_seq.sv
// Post-reset clear sequencer: walks every word once, requesting a zero write per cycle,
// then parks in ST_IDLE until the next reset.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  busy_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(RAM_DEPTH - 1);

  sram_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    busy_o     = 1'b0;
    clr_we_o   = 1'b0;
    clr_addr_o = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        busy_o   = 1'b1;
        clr_we_o = 1'b1;
        ptr_d    = ptr_q + 1'b1;
        if (ptr_q == LastAddr) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end
      end
      ST_IDLE: ;
      default: state_d = ST_CLEAR;
    endcase
  end

endmodule

// File: rtl/sram_1rw_wmask_init.sv
// Single-port SRAM with per-byte write mask, zero-fill after reset and a read-valid strobe.
// Define SRAM_OUT_REG_EN for a second output register stage (read latency 2).
module sram_1rw_wmask_init
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned RAM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                 clk0,
  input  logic                 rst0_n,
  sram_1rw_wmask_init_if.slave bus
);

  localparam int unsigned WMASK_WIDTH = wmask_width(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];
  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  in_range;
  logic                  user_wr;
  logic                  user_rd;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rvalid_q;

  sram_clear_seq #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RAM_DEPTH (RAM_DEPTH)
  ) u_clear_seq (
    .clk_i     (clk0),
    .rst_ni    (rst0_n),
    .busy_o    (busy),
    .clr_we_o  (clr_we),
    .clr_addr_o(clr_addr)
  );

  assign in_range = (32'(bus.addr0) < RAM_DEPTH);
  assign user_wr  = !busy && !bus.csb0 && !bus.web0 && in_range;
  assign user_rd  = !busy && !bus.csb0 && bus.web0;

  // The clear sequencer owns the write port while busy; array has no reset of its own.
  always_ff @(posedge clk0) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (user_wr) begin
      for (int i = 0; i < int'(WMASK_WIDTH); i++) begin
        if (bus.wmask0[i]) mem_q[bus.addr0][8*i +: 8] <= bus.din0[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= user_rd;
      if (user_rd) dout_q <= in_range ? mem_q[bus.addr0] : '0;
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] dout2_q;
  logic                  rvalid2_q;

  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      dout2_q   <= '0;
      rvalid2_q <= 1'b0;
    end else begin
      dout2_q   <= dout_q;
      rvalid2_q <= rvalid_q;
    end
  end

  assign bus.dout0   = dout2_q;
  assign bus.rvalid0 = rvalid2_q;
`else
  assign bus.dout0   = dout_q;
  assign bus.rvalid0 = rvalid_q;
`endif

  assign bus.busy0 = busy;

endmodule

// File: tb/tb_sram_1rw_wmask_init.sv
// Randomised self-checking bench for sram_1rw_wmask_init against an array-based
// reference model with a latency queue.
module tb_sram_1rw_wmask_init;

  localparam int DW    = 32;
  localparam int AW    = 7;
  localparam int Depth = 128;
`ifdef SRAM_OUT_REG_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_1rw_wmask_init_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_if ();

  sram_1rw_wmask_init #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RAM_DEPTH (Depth)
  ) dut (
    .clk0  (clk),
    .rst0_n(rst_n),
    .bus   (bus_if)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] mem_m [Depth];
  logic [31:0] exp_dout;
  logic        exp_rv;
  logic        pend_v [$];
  logic [31:0] pend_d [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = '0;
    exp_dout = '0;
    exp_rv   = 1'b0;
    pend_v.delete();
    pend_d.delete();
    for (int i = 0; i < Lat - 1; i++) begin
      pend_v.push_back(1'b0);
      pend_d.push_back('0);
    end
  endtask

  task automatic idle_inputs();
    bus_if.csb0   = 1'b1;
    bus_if.web0   = 1'b1;
    bus_if.wmask0 = '0;
    bus_if.addr0  = '0;
    bus_if.din0   = '0;
  endtask

  // One access cycle, called at a point #1 after a rising edge.
  task automatic step(input logic csb, input logic web, input logic [3:0] wm,
                      input logic [6:0] a, input logic [31:0] d);
    logic        res_v;
    logic [31:0] res_d;
    bus_if.csb0   = csb;
    bus_if.web0   = web;
    bus_if.wmask0 = wm;
    bus_if.addr0  = a;
    bus_if.din0   = d;
    res_v = 1'b0;
    res_d = '0;
    if (!csb && web) begin
      res_v = 1'b1;
      res_d = mem_m[a];
    end else if (!csb) begin
      for (int i = 0; i < 4; i++) if (wm[i]) mem_m[a][8*i +: 8] = d[8*i +: 8];
    end
    @(posedge clk);
    #1;
    pend_v.push_back(res_v);
    pend_d.push_back(res_d);
    exp_rv = pend_v.pop_front();
    res_d  = pend_d.pop_front();
    if (exp_rv) exp_dout = res_d;
    check_eq("rvalid", 32'(bus_if.rvalid0), 32'(exp_rv));
    check_eq("dout", bus_if.dout0, exp_dout);
  endtask

  task automatic read_expect(input string tag, input logic [6:0] a, input logic [31:0] exp);
    step(1'b0, 1'b1, 4'h0, a, '0);
    for (int i = 0; i < Lat - 1; i++) step(1'b1, 1'b1, 4'h0, '0, '0);
    check_eq(tag, bus_if.dout0, exp);
    check_eq({tag, "_rv"}, 32'(bus_if.rvalid0), 32'd1);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_eq({tag, "_dout"}, bus_if.dout0, 32'h0);
    check_eq({tag, "_rv"}, 32'(bus_if.rvalid0), 32'd0);
    check_eq({tag, "_busy"}, 32'(bus_if.busy0), 32'd1);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Hammers addr 3 with writes/reads during the clear; all must be ignored.
  task automatic wait_clear(input string tag);
    int n = 0;
    check_eq({tag, "_busy0"}, 32'(bus_if.busy0), 32'd1);
    while (bus_if.busy0 && n < 300) begin
      bus_if.csb0   = 1'b0;
      bus_if.web0   = 1'($urandom_range(0, 1));
      bus_if.wmask0 = 4'hF;
      bus_if.addr0  = 7'd3;
      bus_if.din0   = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      n++;
      check_eq({tag, "_rv_busy"}, 32'(bus_if.rvalid0), 32'd0);
      check_eq({tag, "_dout_busy"}, bus_if.dout0, 32'h0);
    end
    idle_inputs();
    check_eq({tag, "_len"}, 32'(n), 32'(Depth));
  endtask

  initial begin
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    do_reset("por");
    wait_clear("clr0");

    read_expect("rd5", 7'd5, 32'h0);
    read_expect("rd3", 7'd3, 32'h0);

    step(1'b0, 1'b0, 4'hF, 7'd10, 32'hFACE_CAFE);
    read_expect("rd10", 7'd10, 32'hFACE_CAFE);
    repeat (5) step(1'b1, 1'b1, 4'h0, '0, '0);
    check_eq("hold", bus_if.dout0, 32'hFACE_CAFE);

    step(1'b0, 1'b0, 4'hF, 7'd11, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 4'b0101, 7'd11, 32'h1122_3344);
    read_expect("mask11", 7'd11, 32'hDE22_BE44);

    step(1'b0, 1'b0, 4'h0, 7'd10, 32'h1234_5678);
    read_expect("nomask", 7'd10, 32'hFACE_CAFE);

    step(1'b0, 1'b0, 4'b1000, 7'd12, 32'h7700_0000);
    step(1'b0, 1'b1, 4'h0, 7'd10, '0);
    step(1'b0, 1'b1, 4'h0, 7'd11, '0);
    step(1'b0, 1'b1, 4'h0, 7'd12, '0);
    step(1'b1, 1'b1, 4'h0, '0, '0);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 4'($urandom),
           ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(8, 23)),
           $urandom);
    end

    step(1'b0, 1'b0, 4'hF, 7'd20, 32'hA5A5_A5A5);
    read_expect("rd20pre", 7'd20, 32'hA5A5_A5A5);
    do_reset("mid");
    wait_clear("clr1");
    read_expect("rd20post", 7'd20, 32'h0);

    do_reset("clrstart");
    repeat (50) begin
      @(posedge clk);
      #1;
    end
    do_reset("midclr");
    wait_clear("clr2");
    read_expect("rd10post", 7'd10, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end

endmodule
